// File: rtl/quad_encoder_ctrl.sv
// quad_encoder_ctrl: quadrature decoder front-end (sync, debounce, step pulse + dir); optional err port via QDEC_ERR_EN
module quad_encoder_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int INIT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic enc_a,
  input  logic enc_b,
  output logic enable,
  output logic dir,
  output logic a_filt,
  output logic b_filt
`ifdef QDEC_ERR_EN
  ,
  output logic err
`endif
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int IW = $clog2(INIT_CYCLES + 1);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_n;
  logic [IW-1:0] init_cnt, init_cnt_n;
  logic [1:0] s1, s2, filt, prev, prev_n, diff;
  logic [CW-1:0] cnt [2];
  logic enable_n, dir_n;
`ifdef QDEC_ERR_EN
  logic err_n;
`endif
  assign a_filt = filt[1];
  assign b_filt = filt[0];
  assign diff = filt ^ prev;
  always_comb begin
    state_n = state;
    init_cnt_n = init_cnt;
    enable_n = 1'b0;
    dir_n = dir;
    prev_n = prev;
`ifdef QDEC_ERR_EN
    err_n = err;
`endif
    if (state == INIT) begin
      prev_n = s2;
      init_cnt_n = init_cnt + 1'b1;
      state_n = (init_cnt == IW'(INIT_CYCLES - 1)) ? RUN : INIT;
    end else begin
      prev_n = filt;
      enable_n = ^diff;
      dir_n = (^diff) ? (filt[1] ^ prev[0]) : dir;
`ifdef QDEC_ERR_EN
      err_n = err | (&diff);
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      init_cnt <= '0;
      s1 <= '0;
      s2 <= '0;
      filt <= '0;
      prev <= '0;
      enable <= 1'b0;
      dir <= 1'b0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
`ifdef QDEC_ERR_EN
      err <= 1'b0;
`endif
    end else begin
      s1 <= {enc_a, enc_b};
      s2 <= s1;
      state <= state_n;
      init_cnt <= init_cnt_n;
      prev <= prev_n;
      enable <= enable_n;
      dir <= dir_n;
`ifdef QDEC_ERR_EN
      err <= err_n;
`endif
      for (int i = 0; i < 2; i++) begin
        if (state == INIT) begin
          filt[i] <= s2[i];
          cnt[i] <= '0;
        end else if (s2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          filt[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end
endmodule
